// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the issue/capture sequencer state type.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_ADD = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MOD = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MOD_CLR,
        MOD_RUN,
        DONE
    } seqState_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage wrapped around the 32-bit ALU: holds operands stable, sequences the
// multi-cycle modulo operation and hands the registered result downstream via valid/ready.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int MOD_LATENCY = 32
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_op,
    input  logic        in_cin,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_cin,
    output logic        alu_reset,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_cout,
    output logic [2:0]  out_op,
    output logic        busy
);

    localparam int CNT_W = $clog2(MOD_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MOD_LATENCY - 1);

    seqState_t        state;
    seqState_t        nextState;
    logic [CNT_W-1:0] modCount;
    logic             accept;
    logic             capture;

    assign in_ready  = (state == IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign alu_reset = reset || (state == MOD_CLR);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Next-state logic; capture marks the edge at which the ALU output is registered.
    always_comb begin
        nextState = state;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nextState = (in_op == ALU_MOD) ? MOD_CLR : EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                nextState = DONE;
            end
            MOD_CLR: nextState = MOD_RUN;
            MOD_RUN: begin
                if (modCount == LAST_COUNT) begin
                    capture   = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // ALU operand registers load only on acceptance so they stay put through DONE.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            modCount   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_cin    <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_op     <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                alu_a   <= in_a;
                alu_b   <= in_b;
                alu_op  <= in_op;
                alu_cin <= in_cin;
            end
            if (state == MOD_CLR) begin
                modCount <= '0;
            end else if (state == MOD_RUN) begin
                modCount <= modCount + CNT_W'(1);
            end
            // Carry is only meaningful for add; other ops report zero.
            if (capture) begin
                out_result <= alu_result;
                out_cout   <= (alu_op == ALU_ADD) && alu_cout;
                out_op     <= alu_op;
            end
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Valid/ready issue and capture stage that sits directly around the 32-bit ALU. It accepts one operation at a time from the decode side, holds the operands and opcode stable on the ALU inputs for as long as the operation needs, and registers the result and carry. It also sequences the multi-cycle modulo operation: it pulses the ALU's reset, waits a fixed latency, then captures. The stage presents the result downstream with a valid/ready handshake.

## Interface
- MOD_LATENCY, 32: ALU clock cycles, counted after the clear pulse, before a modulo result is valid; must be ≥1.
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears the stage on the next rising edge.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  stage can accept; high only in IDLE and only while reset is low.
- in_a, in_b  in  32  operands.
- in_op  in  3  ALU opcode: 000 and, 001 or, 010 xor, 011 nor, 100 slt, 101 add, 110 sub, 111 mod.
- in_cin  in  1  carry-in for add.
- alu_a, alu_b  out  32  registered operands to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_cin  out  1  registered carry-in to the ALU.
- alu_reset  out  1  reset to the ALU's modulo unit; equals reset OR (state==MOD_CLR).
- alu_result  in  32  ALU result.
- alu_cout  in  1  ALU adder carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  captured result.
- out_cout  out  1  captured carry; alu_cout if the op is add, else 0.
- out_op  out  3  opcode of the captured result.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, EXEC, MOD_CLR, MOD_RUN, DONE.
- IDLE:
  - Handshake when in_valid && in_ready.
  - On handshake, latch a, b, op and cin into the alu_* registers.
  - Next state is MOD_CLR if op==111, else EXEC.
- EXEC: one cycle.
  - At its closing edge capture alu_result and alu_cout into the out_* registers.
  - Go to DONE.
- MOD_CLR: one cycle with alu_reset=1.
  - Clear the counter to 0.
  - Go to MOD_RUN.
- MOD_RUN:
  - Increment the counter each cycle.
  - At the edge where counter==MOD_LATENCY-1, capture and go to DONE.
  - Counter width is clog2(MOD_LATENCY+1).
- DONE:
  - out_valid=1.
  - out_* and alu_* are held unchanged until out_valid && out_ready, then go to IDLE.
- The alu_* registers change only on an IDLE handshake. They are stable from acceptance through capture, and also during DONE.
- No pipelining: one operation in flight. In DONE, in_ready=0 even when out_ready=1; the next accept is possible one cycle after the output handshake.
- Reset values:
  - State IDLE, counter 0.
  - alu_a, alu_b, alu_op, alu_cin all 0.
  - out_result, out_cout, out_op all 0.
  - out_valid 0, busy 0.
  - alu_reset=1 while reset is high.
- Reset mid-operation: the operation is abandoned with no output. The stage is in IDLE after the reset edge and in_ready rises in the first cycle after reset deasserts.
- Undefined opcodes do not exist, since all 8 codes are valid.

## Timing
- Acceptance edge is T0.
- Non-mod ops: capture at T0+1, out_valid high in the cycle after T0+1. Minimum issue interval is 3 cycles with out_ready held high.
- Mod: alu_reset is high for exactly the cycle between T0 and T0+1. Capture is at T0+1+MOD_LATENCY, and out_valid is high in the cycle after it.
- out_valid drops on the edge where out_valid && out_ready.
- in_ready and out_valid are never high in the same cycle.

## Structure
- The shared package alu_pkg holds:
  - ALU opcode constants: ALU_AND … ALU_MOD, 3'b000–3'b111.
  - State enum: IDLE, EXEC, MOD_CLR, MOD_RUN, DONE.
- The ALU itself stays a separate instance in the parent.
- No sub-module: FSM, counter and registers sit in one block.

## Test plan
- AND: a=0xF0F0F0F0, b=0x0FF00FF0, op=000 -> out_result=0x00F000F0 and out_cout=0; out_valid high 1 cycle after acceptance; alu_reset stays 0.
- ADD: a=0xFFFFFFFF, b=0x00000001, cin=0, op=101 -> out_result=0x00000000, out_cout=1.
- SUB: a=5, b=7, op=110 -> out_result=0xFFFFFFFE, out_cout=0.
- MOD: a=17, b=5, MOD_LATENCY=32 -> alu_reset is a single-cycle pulse in the cycle after acceptance; out_valid rises 33 edges after acceptance; out_result=2; alu_a and alu_b are constant throughout.
- Backpressure: out_ready low for 5 cycles in DONE -> out_result, out_valid and alu_* are held, in_ready=0. When out_ready rises, in_ready rises the next cycle.
- Reset mid-mod: assert reset 10 cycles into MOD_RUN -> after the edge, state is IDLE and busy=0; out_valid is never asserted; in_ready=1 the cycle after reset deasserts; a subsequent OR of 0x1 and 0x2 gives 0x3.
